// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI responder slice.
//   spi_state_e  : frame-tracking FSM states
//   SpiDataW     : default word width
//   SpiIdleFill  : bit shifted out when no reply word is queued
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StActive    = 2'd1,
    StWaitDesel = 2'd2
  } spi_state_e;

  localparam int unsigned SpiDataW = 8;
  localparam logic SpiIdleFill = 1'b0;

endpackage

// File: rtl/spi_slave_fsm_if.sv
// spi_slave_fsm_if: SPI pins plus the rx/tx valid-ready handshakes of the responder.
//   slave modport  : sclk/ss_n/mosi, tx_data/tx_valid, rx_ready in; miso, tx_ready, rx_data,
//                    rx_valid, rx_overrun, busy out
//   master modport : the mirror image, for the initiator/consumer side
interface spi_slave_fsm_if import spi_pkg::*; #(
  parameter int unsigned DATA_W = SpiDataW
) ();

  logic              sclk;
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic              busy;

  modport slave (
    input  sclk, ss_n, mosi, tx_data, tx_valid, rx_ready,
    output miso, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );

  modport master (
    output sclk, ss_n, mosi, tx_data, tx_valid, rx_ready,
    input  miso, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer for an asynchronous pin, followed by one delay flop
// used for edge detection.
//   clk, reset : system clock, synchronous active-high reset
//   i_d        : asynchronous input pin
//   o_q        : synchronized level
//   o_rise     : one-cycle strobe on a synchronized 0->1 transition
//   o_fall     : one-cycle strobe on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  // [STAGES-1:0] synchronizer, [STAGES] delay flop
  logic [STAGES:0] r_chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= {(STAGES + 1){RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-1:0], i_d};
    end
  end

  assign o_q    = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_chain[STAGES];
  assign o_fall = ~r_chain[STAGES-1] & r_chain[STAGES];

endmodule

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: SPI mode-0 responder, MSB first, oversampled in the clk domain.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spi_slave_fsm_if.slave (SPI pins, rx valid/ready out, tx valid/ready in,
//                sticky rx_overrun, busy)
// Build option: define SPI_SLAVE_OVERRUN_EN to make rx_overrun flag words that overwrite an
// unread rx_data; without it rx_overrun is tied low.
module spi_slave_fsm import spi_pkg::*; #(
  parameter int unsigned DATA_W      = SpiDataW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset,
  spi_slave_fsm_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);
  localparam int unsigned SettleW = $clog2(SYNC_STAGES + 2);
  localparam logic [SettleW-1:0] SettleDone = SettleW'(SYNC_STAGES + 1);

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_ss_s, w_ss_rise, w_ss_fall;
  logic w_mosi_s, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_d(bus.sclk),
    .o_q(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .i_d(bus.ss_n),
    .o_q(w_ss_s), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_d(bus.mosi),
    .o_q(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_sclk_s, w_mosi_rise, w_mosi_fall};

  // Frame FSM
  spi_state_e         r_state, w_state_next;
  logic [SettleW-1:0] r_settle;

  // The ss_n synchronizer resets high, so its first cycles after reset would fake an ss_fall
  // if ss_n is really low; WAIT_DESEL is held until the chain reflects the pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StWaitDesel;
      r_settle <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_settle != SettleDone) r_settle <= r_settle + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:      if (w_ss_fall) w_state_next = StActive;
      StActive:    if (w_ss_rise) w_state_next = StIdle;
      StWaitDesel: if (r_settle == SettleDone && w_ss_s) w_state_next = StIdle;
      default:     w_state_next = StIdle;
    endcase
  end

  logic w_active, w_frame_start, w_bit_rise, w_bit_fall, w_word_done, w_word_start;
  logic [CntW-1:0]   r_bit_cnt;
  logic [DATA_W-2:0] r_rx_shift;
  logic [DATA_W-1:0] w_rx_word;

  assign w_active      = (r_state == StActive);
  assign w_frame_start = (r_state == StIdle) && w_ss_fall;
  // A deselect in the same cycle as an sclk edge wins; the edge is ignored.
  assign w_bit_rise    = w_active && w_sclk_rise && !w_ss_rise;
  assign w_bit_fall    = w_active && w_sclk_fall && !w_ss_rise;
  assign w_word_done   = w_bit_rise && (r_bit_cnt == CntLast);
  // Counter at 0 on a falling edge means the previous word just completed.
  assign w_word_start  = w_frame_start || (w_bit_fall && (r_bit_cnt == '0));
  assign w_rx_word     = {r_rx_shift, w_mosi_s};

  // Receive path
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
    end else if (!w_active || w_ss_rise) begin
      r_bit_cnt <= '0;
    end else if (w_sclk_rise) begin
      r_rx_shift <= w_rx_word[DATA_W-2:0];
      r_bit_cnt  <= (r_bit_cnt == CntLast) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_word_done) begin
      r_rx_data  <= w_rx_word;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && bus.rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_rx_overrun;
  always_ff @(posedge clk) begin
    if (reset || w_ss_fall) begin
      r_rx_overrun <= 1'b0;
    end else if (w_word_done && r_rx_valid && !bus.rx_ready) begin
      r_rx_overrun <= 1'b1;
    end
  end
  assign bus.rx_overrun = r_rx_overrun;
`else
  assign bus.rx_overrun = 1'b0;
`endif

  // Transmit path: one-entry buffer feeding the shift register at each word start
  logic [DATA_W-1:0] r_tx_buf, r_tx_shift;
  logic              r_tx_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_buf   <= '0;
      r_tx_shift <= '0;
      r_tx_full  <= 1'b0;
    end else begin
      if (w_word_start) begin
        r_tx_shift <= r_tx_full ? r_tx_buf : {DATA_W{SpiIdleFill}};
      end else if (w_bit_fall) begin
        r_tx_shift <= {r_tx_shift[DATA_W-2:0], SpiIdleFill};
      end
      // Accept is only possible while empty, so a word start that coincides with tx_valid
      // loads the old (empty) state and keeps the new word for the next start.
      if (bus.tx_valid && !r_tx_full) begin
        r_tx_buf  <= bus.tx_data;
        r_tx_full <= 1'b1;
      end else if (w_word_start) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  assign bus.miso     = w_active ? r_tx_shift[DATA_W-1] : 1'b0;
  assign bus.tx_ready = !r_tx_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = (r_state != StWaitDesel) && !w_ss_s;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: self-checking bench for spi_slave_fsm (DATA_W=8, SYNC_STAGES=2).
// Drives SPI mode-0 frames with sclk phases of H clk cycles, checks a table of single-word
// frames, hand-written corner sequences and randomized multi-word frames against a
// word-level model of the reply buffer and received bytes.
module tb_spi_slave_fsm;

  localparam int unsigned H = 10;
`ifdef SPI_SLAVE_OVERRUN_EN
  localparam logic OvrExp = 1'b1;
`else
  localparam logic OvrExp = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_fsm_if #(.DATA_W(8)) bus ();

  spi_slave_fsm #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] got_q[$];
  bit valid_dip;

  // Every accepted rx handshake lands here.
  always @(posedge clk) begin
    if (!reset && bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] got_at(input int k);
    if (k < got_q.size()) return got_q[k];
    return 8'hxx;
  endfunction

  task automatic tx_offer(input logic [7:0] v);
    int n;
    n = 0;
    while (!bus.tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_before_offer", 16'(bus.tx_ready), 16'd1);
    bus.tx_data  = v;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic frame_begin();
    bus.ss_n = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (H) @(negedge clk);
    bus.ss_n = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  // Shifts nbits of mo MSB-first; mi collects miso sampled just before each rising edge.
  // offer: queue offer_v while the word is in flight. pulse_at: one-cycle rx_ready pulse
  // c cycles into the high phase of the last bit (0 = leave rx_ready alone).
  task automatic spi_word(input logic [7:0] mo, input int nbits, input bit offer,
                          input logic [7:0] offer_v, input int pulse_at,
                          output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.mosi = mo[i];
      if (offer && i == 3) tx_offer(offer_v);
      repeat (H) @(negedge clk);
      mi[i] = bus.miso;
      bus.sclk = 1'b1;
      for (int c = 1; c <= int'(H); c++) begin
        @(negedge clk);
        if (i == 0 && pulse_at != 0) begin
          bus.rx_ready = (c == pulse_at);
          if (c > pulse_at && !bus.rx_valid) valid_dip = 1'b1;
        end
      end
      bus.sclk = 1'b0;
    end
  endtask

  typedef struct {
    bit         preload;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] mi, mi2, v, mo, ov, exp_mi, m_buf;
  logic [7:0] exp_rx[$];
  bit         m_full, off;
  int         nw, sim_hits;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 8'h81, 8'h81, 8'h00};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[3] = '{1'b1, 8'h5A, 8'hC3, 8'hC3, 8'h5A};

    reset = 1'b1;
    bus.ss_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    bus.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_miso", 16'(bus.miso), 16'd0);
    check("rst_tx_ready", 16'(bus.tx_ready), 16'd1);
    check("rst_rx_data", 16'(bus.rx_data), 16'd0);
    check("rst_rx_valid", 16'(bus.rx_valid), 16'd0);
    check("rst_rx_overrun", 16'(bus.rx_overrun), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    reset = 1'b0;
    repeat (H) @(negedge clk);

    // Single-word frames from the table
    for (int k = 0; k < 4; k++) begin
      got_q.delete();
      if (vecs[k].preload) begin
        tx_offer(vecs[k].tx);
        check("vec_tx_ready_low", 16'(bus.tx_ready), 16'd0);
      end
      frame_begin();
      check("vec_busy", 16'(bus.busy), 16'd1);
      spi_word(vecs[k].mosi, 8, 1'b0, 8'h00, 0, mi);
      frame_end();
      check("vec_rx_count", 16'(got_q.size()), 16'd1);
      check("vec_rx_data", 16'(got_at(0)), 16'(vecs[k].exp_rx));
      check("vec_miso", 16'(mi), 16'(vecs[k].exp_miso));
      check("vec_tx_ready_end", 16'(bus.tx_ready), 16'd1);
    end

    // Two-word frame, no reply queued
    got_q.delete();
    frame_begin();
    spi_word(8'h81, 8, 1'b0, 8'h00, 0, mi);
    check("two_tx_ready_mid", 16'(bus.tx_ready), 16'd1);
    spi_word(8'h7E, 8, 1'b0, 8'h00, 0, mi2);
    frame_end();
    check("two_miso0", 16'(mi), 16'd0);
    check("two_miso1", 16'(mi2), 16'd0);
    check("two_rx_count", 16'(got_q.size()), 16'd2);
    check("two_rx0", 16'(got_at(0)), 16'h81);
    check("two_rx1", 16'(got_at(1)), 16'h7E);
    check("two_tx_ready", 16'(bus.tx_ready), 16'd1);

    // Early deselect after 5 bits, then a clean frame
    got_q.delete();
    frame_begin();
    spi_word(8'hAB, 5, 1'b0, 8'h00, 0, mi);
    frame_end();
    check("early_no_rx", 16'(got_q.size()), 16'd0);
    frame_begin();
    spi_word(8'hF0, 8, 1'b0, 8'h00, 0, mi);
    frame_end();
    check("early_next_count", 16'(got_q.size()), 16'd1);
    check("early_next_data", 16'(got_at(0)), 16'hF0);

    // Two words with nobody consuming
    got_q.delete();
    bus.rx_ready = 1'b0;
    frame_begin();
    spi_word(8'h11, 8, 1'b0, 8'h00, 0, mi);
    spi_word(8'h22, 8, 1'b0, 8'h00, 0, mi);
    frame_end();
    check("ovr_rx_valid", 16'(bus.rx_valid), 16'd1);
    check("ovr_rx_data", 16'(bus.rx_data), 16'h22);
    check("ovr_flag", 16'(bus.rx_overrun), 16'(OvrExp));
    frame_begin();
    check("ovr_cleared", 16'(bus.rx_overrun), 16'd0);
    bus.ss_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_drain_count", 16'(got_q.size()), 16'd1);
    check("ovr_drain_data", 16'(got_at(0)), 16'h22);

    // Reset in the middle of a frame, released with ss_n still low
    got_q.delete();
    tx_offer(8'hC7);
    frame_begin();
    spi_word(8'hE1, 3, 1'b0, 8'h00, 0, mi);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_miso", 16'(bus.miso), 16'd0);
    check("mid_rst_tx_ready", 16'(bus.tx_ready), 16'd1);
    check("mid_rst_rx_data", 16'(bus.rx_data), 16'd0);
    check("mid_rst_rx_valid", 16'(bus.rx_valid), 16'd0);
    check("mid_rst_overrun", 16'(bus.rx_overrun), 16'd0);
    repeat (5) @(negedge clk);
    check("mid_rst_busy", 16'(bus.busy), 16'd0);
    spi_word(8'h99, 8, 1'b0, 8'h00, 0, mi);
    check("mid_rst_miso_word", 16'(mi), 16'd0);
    frame_end();
    check("mid_rst_no_rx", 16'(got_q.size()), 16'd0);
    frame_begin();
    spi_word(8'h66, 8, 1'b0, 8'h00, 0, mi);
    frame_end();
    check("mid_rst_next_data", 16'(got_at(0)), 16'h66);

    // rx_ready pulse swept across the completion of a pending second word
    sim_hits = 0;
    for (int o = 1; o <= 8; o++) begin
      bus.rx_ready = 1'b0;
      got_q.delete();
      frame_begin();
      spi_word(8'h3A, 8, 1'b0, 8'h00, 0, mi);
      valid_dip = 1'b0;
      spi_word(8'hC5, 8, 1'b0, 8'h00, o, mi);
      bus.rx_ready = 1'b0;
      frame_end();
      if (got_at(0) === 8'h3A) begin
        check("simul_keep", {7'd0, bus.rx_valid, bus.rx_data}, {7'd0, 1'b1, 8'hC5});
        if (!valid_dip && got_q.size() == 1) sim_hits++;
      end else begin
        check("simul_late", {7'd0, bus.rx_valid, got_at(0)}, {7'd0, 1'b0, 8'hC5});
      end
      bus.rx_ready = 1'b1;
      repeat (3) @(negedge clk);
    end
    check("simul_hit", 16'(sim_hits > 0), 16'd1);

    // Randomized multi-word frames against the word-level model
    check("rand_start_empty", 16'(bus.tx_ready), 16'd1);
    m_full = 1'b0;
    m_buf = '0;
    for (int f = 0; f < 20; f++) begin
      nw = int'($urandom_range(1, 3));
      exp_rx.delete();
      got_q.delete();
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom);
        tx_offer(v);
        m_buf = v;
        m_full = 1'b1;
      end
      frame_begin();
      check("rand_busy", 16'(bus.busy), 16'd1);
      exp_mi = m_full ? m_buf : 8'h00;
      m_full = 1'b0;
      for (int w = 0; w < nw; w++) begin
        mo = 8'($urandom);
        off = 1'($urandom_range(0, 1));
        ov = 8'($urandom);
        spi_word(mo, 8, off, ov, 0, mi);
        exp_rx.push_back(mo);
        check("rand_miso", 16'(mi), 16'(exp_mi));
        if (off) begin
          m_buf = ov;
          m_full = 1'b1;
        end
        // Every completed word is followed by a word start that drains the buffer.
        exp_mi = m_full ? m_buf : 8'h00;
        m_full = 1'b0;
      end
      frame_end();
      check("rand_rx_count", 16'(got_q.size()), 16'(exp_rx.size()));
      for (int w = 0; w < exp_rx.size(); w++) begin
        check("rand_rx_data", 16'(got_at(w)), 16'(exp_rx[w]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
# spi_slave_fsm

Responder end of the team's SPI link: the block receives bytes that an SPI initiator shifts in on `mosi` and returns bytes on `miso`. It runs entirely in the `clk` domain and oversamples the external `sclk`, `ss_n` and `mosi` lines. Received bytes are handed to the I2C-side logic through a valid/ready handshake, and reply bytes are queued through a one-entry transmit buffer. The protocol is SPI mode 0 (CPOL=0, CPHA=0), MSB first, with an active-low slave select.

## Interface
Parameters:
- `DATA_W`, default 8: bits per SPI word.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizers (minimum 2).

Ports:
- `clk`  in  1  system clock; all logic is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `sclk`  in  1  SPI clock from the initiator, asynchronous to `clk`.
- `ss_n`  in  1  slave select, active low, asynchronous.
- `mosi`  in  1  serial data from the initiator, asynchronous.
- `miso`  out  1  serial data to the initiator; driven to 0 while deselected (no tristate).
- `tx_data`  in  DATA_W  reply word.
- `tx_valid`  in  1  `tx_data` is offered.
- `tx_ready`  out  1  the transmit buffer is empty.
- `rx_data`  out  DATA_W  last received word.
- `rx_valid`  out  1  `rx_data` holds an unread word.
- `rx_ready`  in  1  the consumer accepts `rx_data`.
- `rx_overrun`  out  1  sticky flag: an unread word was overwritten.
- `busy`  out  1  a frame is in progress (synchronized `ss_n` is low).

## Operation
- **Synchronization and edge detection.** `sclk`, `ss_n` and `mosi` each pass through `SYNC_STAGES` flops.
  - The `sclk` and `ss_n` synchronizers carry one extra delay flop for edge detection, which produces `sclk_rise`, `sclk_fall`, `ss_fall` and `ss_rise`.
  - `mosi` gets the same extra delay flop so that it stays aligned with the `sclk` edge strobes.
  - Synchronizer reset values: `sclk` chain 0, `ss_n` chain 1.
- **State machine.** States are IDLE, ACTIVE and WAIT_DESEL.
  - IDLE -> ACTIVE on `ss_fall`.
  - ACTIVE -> IDLE on `ss_rise`.
  - After reset the block goes to WAIT_DESEL if the synchronized `ss_n` is 0, otherwise to IDLE. WAIT_DESEL -> IDLE on synchronized `ss_n` = 1. This ensures no frame ever starts mid-transfer.
- **Transmit buffer.** The buffer holds one entry.
  - It captures `tx_data` on `tx_valid && tx_ready`; `tx_ready` then drops.
  - At each word start (on `ss_fall`, or on the `sclk_fall` that follows bit 0 of a word), the buffer is copied into the tx shift register and `tx_ready` rises.
  - If the buffer is empty at a word start, the shift register loads all zeros.
- **`miso`.** Outputs `tx_shift[DATA_W-1]` while ACTIVE.
  - The MSB is valid from the cycle after `ss_fall`.
  - On each `sclk_fall` the tx shift register shifts left by one.
  - `miso` is 0 in IDLE and WAIT_DESEL.
- **Receive path.** On `sclk_rise` in ACTIVE: `rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}` and the bit counter (width $clog2(DATA_W)) increments.
  - When the counter wraps from DATA_W-1 to 0, `rx_data` takes the completed word (including the bit just sampled) and `rx_valid` is set.
  - `rx_valid` clears on `rx_valid && rx_ready`.
- **Multi-word frames.** Frames may contain multiple words: with `ss_n` held low, the bit counter continues and the next word begins immediately.
- **Early deselect.** When `ss_rise` occurs mid-word, the partial word is discarded, the counter resets to 0, `rx_valid` is not raised, and the tx buffer is untouched.
- **Simultaneous events.**
  - `rx_ready` in the same cycle as a new completion: the old word is consumed, the new word is loaded, and `rx_valid` stays 1.
  - `tx_valid` in the same cycle as a word-start load: the load takes the previous buffer contents (or zeros if empty), and the new data is captured for the next word.

## Timing
- Reset values: `miso` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `rx_overrun` 0, `busy` 0; state IDLE or WAIT_DESEL as described above.
- Each edge strobe asserts `SYNC_STAGES`+1 `clk` cycles after the pin transition is first sampled.
- `rx_valid` rises one cycle after the `sclk_rise` strobe of the last bit.
- `miso` updates one cycle after the `sclk_fall` strobe.
- Requirements on the initiator:
  - `sclk` high and low phases each last at least `SYNC_STAGES`+3 `clk` periods, which is at least 5 for the default `SYNC_STAGES`.
  - `ss_n` falls at least `SYNC_STAGES`+3 `clk` periods before the first `sclk` rise.
- `busy` equals the inverted synchronized `ss_n` while not in WAIT_DESEL.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - A word completion while `rx_valid`=1 and `rx_ready`=0 sets `rx_overrun`; the new word still overwrites `rx_data`.
  - `rx_overrun` clears on the next `ss_fall` or on reset.
- `SPI_SLAVE_OVERRUN_EN` undefined: overwrite happens silently, and `rx_overrun` is tied to 0.

## Structure
- Package `spi_pkg`: state enum (IDLE, ACTIVE, WAIT_DESEL), the default `DATA_W` constant, and the idle-fill constant (all zeros).
- Sub-module `spi_sync_edge`: synchronizer of parameterizable depth plus delay flop, with rise/fall strobes and a reset-value parameter.
  - One instance each for `sclk` and `ss_n`.
  - `mosi` uses the same module with the strobes left unused.

## Test plan
- Preload `tx_data`=0xA5, then a frame with `mosi`=0x3C, `sclk` 10 `clk` per phase -> `rx_data`=0x3C with one `rx_valid` rise; `miso` bits are 1,0,1,0,0,1,0,1.
- Two-word frame with no tx preload -> `miso` is all 0 for both words; `rx_data` 0x81 then 0x7E; `tx_ready` stays 1.
- `ss_n` rises after 5 bits -> no `rx_valid`; the next full frame sending 0xF0 yields exactly 0xF0.
- Two words with `rx_ready`=0 -> `rx_data` holds the second word; `rx_overrun`=1 with the macro, 0 without; the next `ss_fall` clears it.
- Assert `reset` mid-frame, then release with `ss_n` still low -> all outputs at reset values; no word received until `ss_n` goes high then low again.
- `rx_ready` asserted in the same cycle as a completion -> `rx_valid` stays 1 and the new word is presented with no loss.
